// File: rtl/jtag_host.sv
// Host-side JTAG driver: turns TAP_RESET / IR_SCAN / DR_SCAN / IDLE_CLOCKS commands
// into TCK/TMS/TDI waveforms and returns the TDO bits captured during the shift.
//
// state | meaning
// IDLE  | waiting for a command, tck held low
// PRE   | optional TAP reset prefix, then Run-Test/Idle -> Shift-xR (or idle ticks)
// SHIFT | one tick per data bit, tms=1 on the last bit (Exit1)
// POST  | Update-xR, Run-Test/Idle
// DONE  | one-cycle response, already able to accept the next command
module jtag_host #(
  parameter int MAX_LEN = 32,
  parameter int DIV     = 2,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               trstn
);

  localparam int CNT_W = LEN_W + 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PAT_W = 10;

  localparam logic [DIV_W-1:0] PH_LOAD = DIV_W'(DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [PAT_W-1:0] RST_PAT = PAT_W'(6'b01_1111);

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, DONE} state_t;

  state_t             state_q, state_n;
  logic [DIV_W-1:0]   cnt_q, cnt_n;
  logic               tck_q, tck_n;
  logic               tms_q, tms_n;
  logic               tdi_q, tdi_n;
  logic               trstn_q;
  logic [CNT_W-1:0]   seg_q, seg_n;
  logic [PAT_W-1:0]   pat_q, pat_n;
  logic [MAX_LEN-1:0] sdata_q, sdata_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [MAX_LEN-1:0] cap_q, cap_n;
  logic [MAX_LEN-1:0] rsp_q, rsp_n;
  logic [1:0]         op_q, op_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic               rseq_q, rseq_n;
  logic               known_q, known_n;

  logic               accept;
  logic [LEN_W-1:0]   eff_len;
  logic               need_rst;
  logic [PAT_W-1:0]   base_pat, pat;
  logic [CNT_W-1:0]   base_cnt, pat_cnt;
  logic [MAX_LEN-1:0] sdata_sh;

  assign cmd_ready = trstn_q && (state_q == IDLE || state_q == DONE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign trstn     = trstn_q;
  assign accept    = cmd_valid && cmd_ready;
  assign sdata_sh  = sdata_q >> 1;

  always_comb begin
    if (cmd_len == '0)
      eff_len = LEN_W'(1);
    else if (cmd_len > LEN_MAX)
      eff_len = LEN_MAX;
    else
      eff_len = cmd_len;
  end

  // Preamble TMS bits, LSB first; IDLE_CLOCKS just appends zeros past the pattern.
  always_comb begin
    need_rst = (cmd_op == OP_RESET) || !known_q;
    base_pat = '0;
    base_cnt = '0;
    case (cmd_op)
      OP_IR:   begin base_pat = PAT_W'(4'b0011); base_cnt = CNT_W'(4); end
      OP_DR:   begin base_pat = PAT_W'(3'b001);  base_cnt = CNT_W'(3); end
      OP_IDLE: begin base_pat = '0;              base_cnt = CNT_W'(eff_len); end
      default: begin base_pat = '0;              base_cnt = '0; end
    endcase
    if (need_rst) begin
      pat     = RST_PAT | (base_pat << 6);
      pat_cnt = CNT_W'(6) + base_cnt;
    end else begin
      pat     = base_pat;
      pat_cnt = base_cnt;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    tck_n   = tck_q;
    tms_n   = tms_q;
    tdi_n   = tdi_q;
    seg_n   = seg_q;
    pat_n   = pat_q;
    sdata_n = sdata_q;
    idx_n   = idx_q;
    cap_n   = cap_q;
    rsp_n   = rsp_q;
    op_n    = op_q;
    len_n   = len_q;
    rseq_n  = rseq_q;
    known_n = known_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE)
          state_n = IDLE;
        if (accept) begin
          op_n    = cmd_op;
          len_n   = eff_len;
          sdata_n = cmd_data;
          cap_n   = '0;
          idx_n   = '0;
          tck_n   = 1'b0;
          tdi_n   = 1'b0;
          if (cmd_op == OP_IDLE && cmd_len == '0) begin
            state_n = DONE;
            rsp_n   = '0;
            rseq_n  = 1'b0;
          end else begin
            state_n = PRE;
            rseq_n  = need_rst;
            tms_n   = pat[0];
            pat_n   = pat >> 1;
            seg_n   = pat_cnt;
            cnt_n   = PH_LOAD;
          end
        end
      end

      default: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - 1'b1;
        end else if (!tck_q) begin
          tck_n = 1'b1;
          cnt_n = PH_LOAD;
          if (state_q == SHIFT)
            cap_n[idx_q] = tdo;
        end else begin
          // End of a tick: this edge opens the next low phase, so tms/tdi may move.
          tck_n = 1'b0;
          cnt_n = PH_LOAD;
          case (state_q)
            PRE: begin
              if (seg_q == CNT_W'(1)) begin
                if (op_q == OP_RESET || op_q == OP_IDLE) begin
                  state_n = DONE;
                  rsp_n   = cap_q;
                  if (rseq_q)
                    known_n = 1'b1;
                end else begin
                  state_n = SHIFT;
                  tms_n   = (len_q == LEN_W'(1));
                  tdi_n   = sdata_q[0];
                  seg_n   = CNT_W'(len_q);
                end
              end else begin
                tms_n = pat_q[0];
                pat_n = pat_q >> 1;
                seg_n = seg_q - 1'b1;
              end
            end
            SHIFT: begin
              if (seg_q == CNT_W'(1)) begin
                state_n = POST;
                tms_n   = 1'b1;
                tdi_n   = 1'b0;
                seg_n   = CNT_W'(2);
              end else begin
                tms_n   = (seg_q == CNT_W'(2));
                tdi_n   = sdata_sh[0];
                sdata_n = sdata_sh;
                idx_n   = idx_q + 1'b1;
                seg_n   = seg_q - 1'b1;
              end
            end
            POST: begin
              if (seg_q == CNT_W'(1)) begin
                state_n = DONE;
                rsp_n   = cap_q;
                if (rseq_q)
                  known_n = 1'b1;
              end else begin
                tms_n = 1'b0;
                seg_n = seg_q - 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      trstn_q <= 1'b0;
      seg_q   <= '0;
      pat_q   <= '0;
      sdata_q <= '0;
      idx_q   <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
      op_q    <= '0;
      len_q   <= '0;
      rseq_q  <= 1'b0;
      known_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      tck_q   <= tck_n;
      tms_q   <= tms_n;
      tdi_q   <= tdi_n;
      trstn_q <= 1'b1;
      seg_q   <= seg_n;
      pat_q   <= pat_n;
      sdata_q <= sdata_n;
      idx_q   <= idx_n;
      cap_q   <= cap_n;
      rsp_q   <= rsp_n;
      op_q    <= op_n;
      len_q   <= len_n;
      rseq_q  <= rseq_n;
      known_q <= known_n;
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host: a behavioural TAP (IR=4 bits, IDCODE=0x12345679)
// on the pins, a table of commands with hand-derived TMS/TDI/response, plus corner sequences.
module tb_jtag_host;

  localparam int MAX_LEN = 32;
  localparam int DIV     = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int LOG_N   = 4096;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = '0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               tck, tms, tdi, trstn;
  logic               tdo = 1'b0;

  jtag_host #(.MAX_LEN(MAX_LEN), .DIV(DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .trstn(trstn)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural TAP ----------------
  typedef enum logic [3:0] {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                            SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
  tap_t        tst = TLR;
  logic [3:0]  ir = 4'h2, ir_sr = '0;
  logic [31:0] dr_sr = '0;

  always @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      tst <= TLR;
      ir  <= 4'h2;
    end else begin
      case (tst)
        TLR:  ir    <= 4'h2;
        CIR:  ir_sr <= 4'b0101;
        SHIR: ir_sr <= {tdi, ir_sr[3:1]};
        UIR:  ir    <= ir_sr;
        CDR:  dr_sr <= (ir == 4'h2) ? 32'h1234_5679 : 32'h0;
        SHDR: dr_sr <= {tdi, dr_sr[31:1]};
        default: ;
      endcase
      case (tst)
        TLR:  tst <= tms ? TLR  : RTI;
        RTI:  tst <= tms ? SDR  : RTI;
        SDR:  tst <= tms ? SIR  : CDR;
        CDR:  tst <= tms ? E1DR : SHDR;
        SHDR: tst <= tms ? E1DR : SHDR;
        E1DR: tst <= tms ? UDR  : PDR;
        PDR:  tst <= tms ? E2DR : PDR;
        E2DR: tst <= tms ? UDR  : SHDR;
        UDR:  tst <= tms ? SDR  : RTI;
        SIR:  tst <= tms ? TLR  : CIR;
        CIR:  tst <= tms ? E1IR : SHIR;
        SHIR: tst <= tms ? E1IR : SHIR;
        E1IR: tst <= tms ? UIR  : PIR;
        PIR:  tst <= tms ? E2IR : PIR;
        E2IR: tst <= tms ? UIR  : SHIR;
        default: tst <= tms ? SDR : RTI;
      endcase
    end
  end

  always @(negedge tck or negedge trstn) begin
    if (!trstn) tdo <= 1'b0;
    else if (tst == SHIR) tdo <= ir_sr[0];
    else if (tst == SHDR) tdo <= dr_sr[0];
    else tdo <= 1'b0;
  end

  // ---------------- monitors ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic tms_log [LOG_N];
  logic tdi_log [LOG_N];
  int   rise_cyc[LOG_N];
  int   ntick = 0;
  always @(posedge tck) begin
    if (ntick < LOG_N) begin
      tms_log[ntick]  = tms;
      tdi_log[ntick]  = tdi;
      rise_cyc[ntick] = cyc;
    end
    ntick = ntick + 1;
  end

  int rsp_total = 0;
  always @(negedge clk) if (rsp_valid === 1'b1) rsp_total = rsp_total + 1;

  // tms/tdi must never move while tck is high
  int   pin_glitch = 0;
  logic p_tms, p_tdi;
  always @(negedge clk) begin
    if (!rst && tck === 1'b1 && (tms !== p_tms || tdi !== p_tdi))
      pin_glitch = pin_glitch + 1;
    p_tms = tms;
    p_tdi = tdi;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]         op;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] data;
    int                 ticks;
    logic [63:0]        tms_seq;
    logic [63:0]        tdi_seq;
    logic [MAX_LEN-1:0] rsp;
  } vec_t;

  vec_t vecs[10];

  task automatic wait_ready(input string nm);
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " ready"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int base, lat, bad;
    logic [63:0] tg, dg;
    wait_ready(nm);
    base      = ntick;
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_len   = v.len;
    cmd_data  = v.data;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({nm, " latency"}, 64'(lat), 64'(v.ticks * 2 * DIV));
    chk({nm, " ready_at_rsp"}, 64'(cmd_ready), 64'd1);
    chk({nm, " rsp_data"}, 64'(rsp_data), 64'(v.rsp));
    chk({nm, " ticks"}, 64'(ntick - base), 64'(v.ticks));
    tg = '0;
    dg = '0;
    bad = 0;
    for (int i = 0; i < v.ticks && i < 64 && base + i < ntick && base + i < LOG_N; i++) begin
      tg[i] = tms_log[base + i];
      dg[i] = tdi_log[base + i];
      if (i > 0 && rise_cyc[base + i] - rise_cyc[base + i - 1] != 2 * DIV) bad++;
    end
    chk({nm, " tms"}, tg, v.tms_seq);
    chk({nm, " tdi"}, dg, v.tdi_seq);
    chk({nm, " tck_period"}, 64'(bad), 64'd0);
    @(negedge clk);
    chk({nm, " rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int base, w, rsp_before;

    vecs[0] = '{2'd2, 6'd8,  32'h0000_00A5, 19, 64'h3_005F,        64'h1_4A00,        32'h0000_0079};
    vecs[1] = '{2'd0, 6'd0,  32'h0,          6, 64'h1F,            64'h0,             32'h0};
    vecs[2] = '{2'd1, 6'd4,  32'h2,         10, 64'h183,           64'h20,            32'h5};
    vecs[3] = '{2'd2, 6'd32, 32'h0,         37, 64'hC_0000_0001,   64'h0,             32'h1234_5679};
    vecs[4] = '{2'd3, 6'd3,  32'hFFFF_FFFF,  3, 64'h0,             64'h0,             32'h0};
    vecs[5] = '{2'd3, 6'd0,  32'h0,          0, 64'h0,             64'h0,             32'h0};
    vecs[6] = '{2'd2, 6'd0,  32'h1,          6, 64'h19,            64'h8,             32'h1};
    vecs[7] = '{2'd2, 6'd40, 32'hFFFF_FFFF, 37, 64'hC_0000_0001,   64'h7_FFFF_FFF8,   32'h1234_5679};
    vecs[8] = '{2'd1, 6'd4,  32'hF,         10, 64'h183,           64'hF0,            32'h5};
    vecs[9] = '{2'd2, 6'd8,  32'h3C,        13, 64'hC01,           64'h1E0,           32'h0};

    repeat (3) @(negedge clk);
    chk("reset tck", 64'(tck), 64'd0);
    chk("reset tms", 64'(tms), 64'd1);
    chk("reset tdi", 64'(tdi), 64'd0);
    chk("reset trstn", 64'(trstn), 64'd0);
    chk("reset cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_data", 64'(rsp_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset trstn", 64'(trstn), 64'd1);
    chk("post-reset cmd_ready", 64'(cmd_ready), 64'd1);
    chk("idle tck", 64'(tck), 64'd0);

    for (int k = 0; k < 10; k++)
      run_vec(vecs[k], $sformatf("vec%0d", k));

    // back-to-back IDLE_CLOCKS len=0 with cmd_valid held
    wait_ready("b2b");
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_len   = '0;
    @(negedge clk);
    chk("b2b first rsp", 64'(rsp_valid), 64'd1);
    chk("b2b ready in rsp", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    chk("b2b second rsp", 64'(rsp_valid), 64'd1);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b quiet", 64'(rsp_valid), 64'd0);

    // reset during the 10th shift of a 32-bit DR scan
    wait_ready("abort");
    rsp_before = rsp_total;
    base       = ntick;
    cmd_valid  = 1'b1;
    cmd_op     = 2'd2;
    cmd_len    = 6'd32;
    cmd_data   = 32'hDEAD_BEEF;
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (ntick < base + 13 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("abort reached shift10", 64'(ntick - base), 64'd13);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort tck", 64'(tck), 64'd0);
    chk("abort tms", 64'(tms), 64'd1);
    chk("abort tdi", 64'(tdi), 64'd0);
    chk("abort trstn", 64'(trstn), 64'd0);
    chk("abort cmd_ready", 64'(cmd_ready), 64'd0);
    chk("abort rsp_data", 64'(rsp_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort ready after rst", 64'(cmd_ready), 64'd1);
    repeat (4) @(negedge clk);
    chk("abort no rsp", 64'(rsp_total - rsp_before), 64'd0);

    // tap_known was cleared: reset prefix must come back
    run_vec(vecs[0], "after_abort");

    chk("rsp pulse total", 64'(rsp_total), 64'd13);
    chk("tms/tdi stable while tck high", 64'(pin_glitch), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_host.md
Name: jtag_host

Overview:
- Host-side JTAG driver. It is the initiator that generates TCK/TMS/TDI and samples TDO to drive the device TAP through its state machine.
- It accepts high-level commands (TAP reset, IR scan, DR scan, idle clocks) on a valid/ready interface in the system clock domain.
- It returns the captured TDO bits as a one-cycle response.
- It sits between the debug/test controller logic and the JTAG pins of the on-chip or external TAP.

Parameters:
- MAX_LEN, 32: maximum scan length in bits; width of the data buses.
- DIV, 2: clk cycles per TCK half-period; must be >= 1.
- LEN_W, $clog2(MAX_LEN+1): width of cmd_len.

Ports:
- clk  in  1  system clock; TCK is derived from it.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  host idle and able to accept a command.
- cmd_op  in  2  command code: 0=TAP_RESET, 1=IR_SCAN, 2=DR_SCAN, 3=IDLE_CLOCKS.
- cmd_len  in  LEN_W  scan bit count, or TCK count for IDLE_CLOCKS.
- cmd_data  in  MAX_LEN  TDI bits, shifted LSB first.
- rsp_valid  out  1  one-cycle pulse when the command completes.
- rsp_data  out  MAX_LEN  captured TDO; bit i is the TDO value sampled during shift i; bits >= len are 0.
- tck  out  1  test clock.
- tms  out  1  test mode select.
- tdi  out  1  test data in, to the TAP.
- tdo  in  1  test data out, from the TAP.
- trstn  out  1  TAP reset, active low.

Behaviour:
- Reset values (rst=1, and on the cycle it takes effect):
  - tck=0, tms=1, tdi=0, trstn=0, cmd_ready=0, rsp_valid=0, rsp_data=0.
  - Internal tap_known=0.
- First cycle after rst deasserts: trstn=1, cmd_ready=1.
- Handshake:
  - A command is accepted on a clk edge where cmd_valid & cmd_ready; cmd_op, cmd_len and cmd_data are latched on that edge.
  - cmd_ready is low from acceptance until rsp_valid.
  - cmd_ready returns high in the same cycle that rsp_valid pulses, so back-to-back commands have no gap.
- TCK generation:
  - Each tick is 2*DIV clk cycles: tck=0 for DIV cycles, then tck=1 for DIV cycles.
  - tms and tdi change only on the clk edge that starts a low phase.
  - tdo is sampled on the clk edge where tck goes 0->1.
  - tck stays 0 whenever the host is idle.
- Length clamping:
  - Scan with len=0 is treated as len=1.
  - Any len > MAX_LEN is treated as MAX_LEN.
- FSM states: IDLE, PRE, SHIFT, POST, DONE.
  - IDLE -> PRE on acceptance; an IDLE_CLOCKS command with len=0 goes straight to DONE.
  - PRE emits the preamble TMS sequence and goes to SHIFT. TAP_RESET and IDLE_CLOCKS have no shift, so they go to DONE.
  - SHIFT emits len ticks, then goes to POST.
  - POST emits the exit sequence, then goes to DONE.
  - DONE lasts exactly one cycle: it pulses rsp_valid and returns to IDLE.
- TMS sequences (host assumes the TAP starts and ends in Run-Test/Idle):
  - TAP_RESET: 1,1,1,1,1,0 (6 ticks); sets tap_known=1; rsp_data=0.
  - IR_SCAN:
    - Preamble 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
    - Shift ticks: tms=0, except tms=1 on the last bit (Exit1-IR).
    - Post 1,0 (Update-IR, Idle).
    - Total 4+len+2 ticks.
  - DR_SCAN:
    - Preamble 1,0,0.
    - Shift as for IR_SCAN.
    - Post 1,0.
    - Total 3+len+2 ticks.
  - IDLE_CLOCKS: len ticks with tms=0; rsp_data=0.
- TDI: cmd_data[i] drives tdi during shift tick i; tdi=0 during all non-shift ticks.
- Capture: during shift tick i, the sampled tdo is written to rsp_data bit i. rsp_data holds its value until the next command completes.
- Auto-reset: if IR_SCAN, DR_SCAN or IDLE_CLOCKS is accepted while tap_known=0, the TAP_RESET sequence is prepended in PRE before the normal preamble. The command still produces a single rsp_valid.
- Reset mid-operation:
  - Outputs return to their reset values on the next edge.
  - The in-flight command is dropped with no rsp_valid.
  - tap_known is cleared.

Test Plan:
- TAP_RESET, DIV=2 -> 6 tck periods of 4 clk each; tms 1,1,1,1,1,0 sampled at tck rise; rsp_valid one cycle later; rsp_data=0; cmd_ready high in the same cycle.
- IR_SCAN len=4, data=0x2, against a TAP model capturing 4'b0101 -> tms 1,1,0,0,0,0,0,1,1,0; tdi 0,1,0,0 during shift; rsp_data=0x5.
- DR_SCAN len=32, data=0, after IDCODE is selected, model IDCODE=0x1234_5679 -> 37 ticks; rsp_data=0x1234_5679.
- DR_SCAN len=8 issued directly after rst -> tms starts 1,1,1,1,1,0,1,0,0; 19 ticks total; single rsp_valid.
- IDLE_CLOCKS len=0 -> rsp_valid on the cycle after acceptance, no tck edge. IDLE_CLOCKS len=3 -> 3 ticks with tms=0, tdi=0.
- rst asserted during the 10th shift of a DR_SCAN len=32 -> tck=0, tms=1, trstn=0 next edge; no rsp_valid; cmd_ready=1 one cycle after rst drops.
